// File: rtl/dec_conv_arbiter.sv
// dec_conv_arbiter: round-robin sharing of one binary-to-ASCII decimal converter among NUM_REQ requesters.
// Build option DEC_CONV_BLANK_ZEROS_EN replaces leading zeros of the result with spaces.
module dec_conv_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [8*NUM_REQ-1:0]       i_value,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic                       o_result_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_result_id,
    output logic [7:0]                 o_hundreds,
    output logic [7:0]                 o_tens,
    output logic [7:0]                 o_units,
    output logic                       o_busy,
    output logic                       o_timeout_err,
    output logic                       o_conv_start,
    output logic [7:0]                 o_conv_value,
    input  logic                       i_conv_done,
    input  logic [7:0]                 i_conv_hundreds,
    input  logic [7:0]                 i_conv_tens,
    input  logic [7:0]                 i_conv_units
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [IW-1:0] ptr, id, sel, off;
    logic [IW:0] sum;
    logic [2*NUM_REQ-1:0] dbl;
    logic hit, tmo, tmo_flag;
    logic [CW-1:0] cnt;
    logic [7:0] val, hund, tens, units, h_in, t_in;

    // Rotate the request vector so the search always starts at the pointer.
    always_comb begin
        dbl = {i_req, i_req} >> ptr;
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && dbl[i]) begin
                hit = 1'b1;
                off = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        sel = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
    end

`ifdef DEC_CONV_BLANK_ZEROS_EN
    logic blank_h;
    assign blank_h = i_conv_hundreds == 8'h30;
    assign h_in    = blank_h ? 8'h20 : i_conv_hundreds;
    assign t_in    = (blank_h && i_conv_tens == 8'h30) ? 8'h20 : i_conv_tens;
`else
    assign h_in = i_conv_hundreds;
    assign t_in = i_conv_tens;
`endif

    assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = hit ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = (i_conv_done || tmo) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr      <= '0;
            id       <= '0;
            val      <= '0;
            cnt      <= '0;
            tmo_flag <= 1'b0;
            hund     <= 8'h30;
            tens     <= 8'h30;
            units    <= 8'h30;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        id  <= sel;
                        val <= 8'(i_value >> {sel, 3'b000});
                    end
                end
                START: begin
                    cnt      <= '0;
                    tmo_flag <= 1'b0;
                end
                WAIT: begin
                    // A done arriving on the last allowed cycle still wins over the timeout.
                    if (i_conv_done) begin
                        hund     <= h_in;
                        tens     <= t_in;
                        units    <= i_conv_units;
                        tmo_flag <= 1'b0;
                    end else if (tmo) begin
                        hund     <= 8'h3F;
                        tens     <= 8'h3F;
                        units    <= 8'h3F;
                        tmo_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ptr <= (id == IW'(NUM_REQ - 1)) ? '0 : id + IW'(1);
            endcase
        end
    end

    assign o_busy         = state != IDLE;
    assign o_conv_start   = state == START;
    assign o_result_valid = state == RESP;
    assign o_timeout_err  = (state == RESP) && tmo_flag;
    assign o_grant        = (state == RESP) ? (NUM_REQ'(1) << id) : '0;
    assign o_result_id    = id;
    assign o_conv_value   = val;
    assign o_hundreds     = hund;
    assign o_tens         = tens;
    assign o_units        = units;
endmodule

// File: tb/tb_dec_conv_arbiter.sv
// tb_dec_conv_arbiter: scoreboard bench for dec_conv_arbiter with a delay-programmable converter model.
module tb_dec_conv_arbiter;
    localparam int NR = 4;
    localparam int TO = 64;
    localparam int IW = $clog2(NR);

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic [NR-1:0] i_req;
    logic [8*NR-1:0] i_value;
    logic [NR-1:0] o_grant;
    logic o_result_valid;
    logic [IW-1:0] o_result_id;
    logic [7:0] o_hundreds, o_tens, o_units;
    logic o_busy, o_timeout_err, o_conv_start;
    logic [7:0] o_conv_value;
    logic i_conv_done;
    logic [7:0] i_conv_hundreds, i_conv_tens, i_conv_units;

    dec_conv_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_value(i_value),
        .o_grant(o_grant), .o_result_valid(o_result_valid), .o_result_id(o_result_id),
        .o_hundreds(o_hundreds), .o_tens(o_tens), .o_units(o_units),
        .o_busy(o_busy), .o_timeout_err(o_timeout_err), .o_conv_start(o_conv_start),
        .o_conv_value(o_conv_value), .i_conv_done(i_conv_done),
        .i_conv_hundreds(i_conv_hundreds), .i_conv_tens(i_conv_tens), .i_conv_units(i_conv_units)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {int id; logic [23:0] ch; logic to;} exp_t;
    exp_t sb[$];
    exp_t cur;
    int checks = 0, failures = 0;
    int cyc = 0, start_cnt = 0, start_cyc = 0, grant_cyc = 0;
    int conv_delay = 0, md;
    logic [7:0] start_val, mv;

    function automatic logic [23:0] exp_chars(input logic [7:0] v);
        logic [7:0] h, t, u;
        h = 8'h30 + v / 100;
        t = 8'h30 + (v / 10) % 10;
        u = 8'h30 + v % 10;
`ifdef DEC_CONV_BLANK_ZEROS_EN
        if (h == 8'h30) begin
            h = 8'h20;
            if (t == 8'h30) t = 8'h20;
        end
`endif
        return {h, t, u};
    endfunction

    task automatic run_reqs(input logic [NR-1:0] mask, input logic [NR-1:0] keep, input int n);
        int got = 0;
        int left = 400;
        i_req = mask;
        while (got < n && left > 0) begin
            @(negedge i_clk);
            left--;
            if (o_result_valid === 1'b1) begin
                got++;
                i_req = (got == n) ? '0 : (i_req & ~(o_grant & ~keep));
            end
        end
        i_req = '0;
        @(negedge i_clk);
        checks++;
        if (got != n || sb.size() != 0) begin
            failures++;
            $display("FAIL grants got=%0d exp=%0d pending_expected=%0d", got, n, sb.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_grant, o_result_valid, o_busy, o_timeout_err, o_conv_start} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got grant=%b valid=%b busy=%b err=%b start=%b exp all 0",
                     o_grant, o_result_valid, o_busy, o_timeout_err, o_conv_start);
        end
        checks++;
        if (o_result_id !== '0 || o_conv_value !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs got id=%0d value=%0d exp 0 0", o_result_id, o_conv_value);
        end
        checks++;
        if ({o_hundreds, o_tens, o_units} !== {3{8'h30}}) begin
            failures++;
            $display("FAIL reset_chars got=%h exp=303030", {o_hundreds, o_tens, o_units});
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b exp 0", o_busy);
        end
    endtask

    task automatic test_round_robin;
        i_value = {8'd255, 8'd200, 8'd50, 8'd5};
        conv_delay = 3;
        sb.push_back('{0, exp_chars(8'd5), 1'b0});
        sb.push_back('{1, exp_chars(8'd50), 1'b0});
        sb.push_back('{2, exp_chars(8'd200), 1'b0});
        sb.push_back('{3, exp_chars(8'd255), 1'b0});
        sb.push_back('{0, exp_chars(8'd5), 1'b0});
        run_reqs(4'b1111, 4'b0001, 5);
    endtask

    task automatic test_single;
        int left = 200;
        int s0 = start_cnt;
        i_value[7:0] = 8'd123;
        conv_delay = 10;
        sb.push_back('{0, exp_chars(8'd123), 1'b0});
        i_req = 4'b0001;
        while (left > 0 && o_conv_start !== 1'b1) begin
            @(negedge i_clk);
            left--;
        end
        i_value[7:0] = 8'd200;
        while (left > 0 && o_result_valid !== 1'b1) begin
            @(negedge i_clk);
            left--;
        end
        i_req = '0;
        checks++;
        if (o_conv_value !== 8'd123) begin
            failures++;
            $display("FAIL operand_held got=%0d exp=123", o_conv_value);
        end
        @(negedge i_clk);
        checks++;
        if (left == 0 || sb.size() != 0) begin
            failures++;
            $display("FAIL single_done got left=%0d pending=%0d exp result seen", left, sb.size());
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL start_pulses got=%0d exp=1", start_cnt - s0);
        end
        checks++;
        if (start_val !== 8'd123) begin
            failures++;
            $display("FAIL start_value got=%0d exp=123", start_val);
        end
        checks++;
        if (grant_cyc - start_cyc != 11) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=11", grant_cyc - start_cyc);
        end
    endtask

    task automatic test_wrap;
        conv_delay = 2;
        i_value[31:24] = 8'd0;
        sb.push_back('{3, exp_chars(8'd0), 1'b0});
        run_reqs(4'b1000, 4'b0000, 1);
        i_value[15:8] = 8'd7;
        i_value[31:24] = 8'd40;
        sb.push_back('{1, exp_chars(8'd7), 1'b0});
        sb.push_back('{3, exp_chars(8'd40), 1'b0});
        run_reqs(4'b1010, 4'b0000, 2);
    endtask

    task automatic test_done_at_timeout;
        i_value[15:8] = 8'd42;
        conv_delay = TO;
        sb.push_back('{1, exp_chars(8'd42), 1'b0});
        run_reqs(4'b0010, 4'b0000, 1);
        checks++;
        if (grant_cyc - start_cyc != TO + 1) begin
            failures++;
            $display("FAIL done_at_timeout_latency got=%0d exp=%0d", grant_cyc - start_cyc, TO + 1);
        end
    endtask

    task automatic test_timeout;
        int bad = 0;
        i_value[23:16] = 8'd9;
        conv_delay = 0;
        sb.push_back('{2, {3{8'h3F}}, 1'b1});
        run_reqs(4'b0100, 4'b0000, 1);
        checks++;
        if (grant_cyc - start_cyc != TO + 1) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=%0d", grant_cyc - start_cyc, TO + 1);
        end
        i_conv_done = 1'b1;
        @(negedge i_clk);
        i_conv_done = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL late_done got busy_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid_wait;
        i_value[15:8] = 8'd77;
        conv_delay = 0;
        i_req = 4'b0010;
        repeat (6) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b1 || o_conv_value !== 8'd77) begin
            failures++;
            $display("FAIL pre_reset got busy=%b value=%0d exp 1 77", o_busy, o_conv_value);
        end
        #2;
        i_rst_n = 1'b0;
        i_req = '0;
        #1;
        checks++;
        if ({o_busy, o_conv_start, o_grant, o_result_valid, o_timeout_err} !== '0) begin
            failures++;
            $display("FAIL async_reset_ctrl got busy=%b start=%b grant=%b valid=%b err=%b exp all 0",
                     o_busy, o_conv_start, o_grant, o_result_valid, o_timeout_err);
        end
        checks++;
        if (o_conv_value !== 8'd0 || {o_hundreds, o_tens, o_units} !== {3{8'h30}}) begin
            failures++;
            $display("FAIL async_reset_regs got value=%0d chars=%h exp 0 303030",
                     o_conv_value, {o_hundreds, o_tens, o_units});
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_mid_reset got busy=%b exp 0", o_busy);
        end
        i_value[7:0] = 8'd33;
        i_value[31:24] = 8'd250;
        conv_delay = 4;
        sb.push_back('{0, exp_chars(8'd33), 1'b0});
        sb.push_back('{3, exp_chars(8'd250), 1'b0});
        run_reqs(4'b1001, 4'b0000, 2);
    endtask

    initial begin
        i_req = '0;
        i_value = '0;
        i_conv_done = 1'b0;
        i_conv_hundreds = 8'h30;
        i_conv_tens = 8'h30;
        i_conv_units = 8'h30;
        fork
            forever begin
                @(posedge i_clk);
                cyc++;
            end
            forever begin
                @(negedge i_clk);
                if (o_result_valid === 1'b1) begin
                    grant_cyc = cyc;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_result got id=%0d exp none", o_result_id);
                    end else begin
                        cur = sb.pop_front();
                        if ({o_grant, o_result_id, o_hundreds, o_tens, o_units, o_timeout_err} !==
                            {NR'(1) << cur.id, IW'(cur.id), cur.ch, cur.to}) begin
                            failures++;
                            $display("FAIL result got grant=%b id=%0d chars=%h err=%b exp grant=%b id=%0d chars=%h err=%b",
                                     o_grant, o_result_id, {o_hundreds, o_tens, o_units}, o_timeout_err,
                                     NR'(1) << cur.id, cur.id, cur.ch, cur.to);
                        end
                    end
                end else if (o_grant !== '0 || o_timeout_err !== 1'b0) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_pulse got grant=%b err=%b exp 0 0", o_grant, o_timeout_err);
                end
                if (o_conv_start === 1'b1) begin
                    start_cnt++;
                    start_cyc = cyc;
                    start_val = o_conv_value;
                end
            end
            forever begin
                @(negedge i_clk);
                if (o_conv_start === 1'b1 && conv_delay > 0) begin
                    mv = o_conv_value;
                    md = conv_delay;
                    repeat (md) @(negedge i_clk);
                    i_conv_hundreds = 8'h30 + mv / 100;
                    i_conv_tens = 8'h30 + (mv / 10) % 10;
                    i_conv_units = 8'h30 + mv % 10;
                    i_conv_done = 1'b1;
                    @(negedge i_clk);
                    i_conv_done = 1'b0;
                end
            end
        join_none
        test_reset;
        test_round_robin;
        test_single;
        test_wrap;
        test_done_at_timeout;
        test_timeout;
        test_reset_mid_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
